generator_addr_out: RTL and testbench
=====================================

GENERATOR_ADDR_OUT -- requirements
Module: generator_addr_out

Interface
REQ-001 SHALL have parameter END_ROW, default 16, row pitch in words of the target buffer.
REQ-002 SHALL have parameter HEIGHT, default 32, target buffer depth in words; AW = $clog2(HEIGHT).
REQ-003 SHALL have parameter DATA_W, default 16, word width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port start  input  1  begin one 4x4 tile write.
REQ-007 SHALL have port j  input  8  tile column index.
REQ-008 SHALL have port k  input  8  tile row-block index.
REQ-009 SHALL have port in_valid  input  1  producer word valid.
REQ-010 SHALL have port in_data  input  DATA_W  producer word.
REQ-011 SHALL have port in_ready  output  1  block accepts a word.
REQ-012 SHALL have port wr_en  output  1  buffer write strobe.
REQ-013 SHALL have port wr_addr  output  AW  buffer write address.
REQ-014 SHALL have port wr_data  output  DATA_W  buffer write data.
REQ-015 SHALL have port busy  output  1  tile in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse, tile complete.

Function
REQ-017 SHALL implement FSM IDLE -> WRITE -> DONE -> IDLE.
REQ-018 IDLE: start=1 SHALL latch j,k, clear both counters, go WRITE; start is ignored in WRITE and DONE.
REQ-019 WRITE: in_ready SHALL be 1; in_ready SHALL be 0 in IDLE and DONE.
REQ-020 A word SHALL be accepted only on in_valid & in_ready; in_valid=0 holds counters and address, with no write.
REQ-021 Two 2-bit counters SHALL be used: c0 (fast) advances on each accepted word; c1 (slow) advances on c0 wrap 3->0.
REQ-022 Address for an accepted word SHALL be (END_ROW*4*k + 4*j + END_ROW*c0 + c1) using the latched j,k, computed at 32 bits and truncated modulo 2^AW.
REQ-023 wr_en, wr_addr and wr_data SHALL be registered: they are asserted exactly one cycle after acceptance, with wr_en=1 for one cycle per word.
REQ-024 On the 16th accepted word (c0=3, c1=3), the FSM SHALL go to DONE; that word is still written (REQ-023).
REQ-025 DONE SHALL last one cycle, assert done=1 coincident with the 16th wr_en, then go to IDLE.
REQ-026 busy SHALL be 1 in WRITE and DONE, and 0 in IDLE.
REQ-027 start asserted in the DONE cycle SHALL be ignored; a new tile needs start in IDLE.
REQ-028 Back-to-back accepts SHALL sustain one word per cycle with no bubbles.

Reset
REQ-029 rst=0 at a clock edge SHALL force IDLE, c0=c1=0, latched j,k=0, wr_en=0, wr_addr=0, wr_data=0, done=0, busy=0 and in_ready=0.
REQ-030 Reset mid-tile SHALL abandon the tile with no further wr_en and no done pulse.

Structure
REQ-031 FSM state encoding (IDLE=0, WRITE=1, DONE=2) and TILE_WORDS=16 SHALL live in the shared codebase package.
REQ-032 The two 2-bit counters SHALL be instances of the existing Counter sub-module (width 2, enable, carry-out), chained by carry, with synchronous clear adapted to active-low rst.

Verification (bench params END_ROW=4, HEIGHT=64, DATA_W=16)
REQ-033 Reset: hold rst=0 for 3 cycles with in_valid=1 and start=1 -> all outputs 0, no wr_en.
REQ-034 Full tile: start with k=1, j=2; in_valid=1 continuously; data 0..15 -> wr_addr sequence 24,28,32,36,25,29,33,37,26,30,34,38,27,31,35,39 with data 0..15; done pulses with the 16th write; 16 consecutive wr_en cycles.
REQ-035 Stalls: same tile with in_valid toggled 1,0,1,0 -> wr_en only after accepted words, order unchanged, done once.
REQ-036 Wrap: k=3, j=15 (base 108) -> first wr_addr = 108 mod 64 = 44.
REQ-037 Reset mid-tile: rst=0 after 7 accepts -> no further wr_en, no done; a new start then begins again at c0=c1=0.
REQ-038 start during WRITE with different j,k -> ignored; addresses follow the original latched j,k.

Source files
------------

// File: rtl/generator_addr_out_pkg.sv
// Shared definitions for the 4x4 tile address generator: state encoding, tile size
// and the tile address formula.
package generator_addr_out_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StWrite = 2'd1;
    localparam state_t StDone  = 2'd2;

    localparam int unsigned TileWords = 16;

    // Word (c0, c1) of tile (j, k) lands at row c0, column c1 of the tile, at 32 bits.
    function automatic logic [31:0] tile_addr(input int unsigned end_row,
                                              input logic [7:0] j, input logic [7:0] k,
                                              input logic [1:0] c0, input logic [1:0] c1);
        return end_row * 32'd4 * 32'(k) + 32'd4 * 32'(j) + end_row * 32'(c0) + 32'(c1);
    endfunction

endpackage

// File: rtl/generator_addr_out_counter.sv
// Small enabled up-counter with synchronous clear and a carry-out that fires on the
// enabled wrap from all-ones back to zero, so instances chain by carry.
module generator_addr_out_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             carry
);

    assign carry = en & (&count);

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/generator_addr_out.sv
// Writes one 4x4 tile of producer words into a row-pitched buffer, column-major
// within the tile, with registered write strobe, address and data.
module generator_addr_out
    import generator_addr_out_pkg::*;
#(
    parameter int unsigned END_ROW = 16,
    parameter int unsigned HEIGHT  = 32,
    parameter int unsigned DATA_W  = 16,
    localparam int unsigned AW     = $clog2(HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        j,
    input  logic [7:0]        k,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    state_t         state_q, state_d;
    logic [7:0]     j_q, k_q;
    logic [1:0]     c0, c1;
    logic           c0_carry, c1_carry;
    logic           launch, accept, last;
    logic [AW-1:0]  addr_next;

    assign launch   = (state_q == StIdle) & start;
    assign in_ready = (state_q == StWrite);
    assign accept   = in_valid & in_ready;
    // The slow counter only carries out on the word that completes the tile.
    assign last     = c1_carry;
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);

    assign addr_next = AW'(tile_addr(END_ROW, j_q, k_q, c0, c1));

    generator_addr_out_counter #(
        .WIDTH (2)
    ) u_c0 (
        .clk   (clk),
        .rst   (rst),
        .clr   (launch),
        .en    (accept),
        .count (c0),
        .carry (c0_carry)
    );

    generator_addr_out_counter #(
        .WIDTH (2)
    ) u_c1 (
        .clk   (clk),
        .rst   (rst),
        .clr   (launch),
        .en    (c0_carry),
        .count (c1),
        .carry (c1_carry)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StWrite;
            StWrite: if (last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            j_q     <= '0;
            k_q     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state_q <= state_d;
            wr_en   <= accept;
            if (launch) begin
                j_q <= j;
                k_q <= k;
            end
            if (accept) begin
                wr_addr <= addr_next;
                wr_data <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_generator_addr_out.sv
// Self-checking bench for generator_addr_out: directed tile tables plus randomized
// tiles checked cycle by cycle against a word-count reference model.
module tb_generator_addr_out;

    localparam int unsigned END_ROW = 4;
    localparam int unsigned HEIGHT  = 64;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned AW      = $clog2(HEIGHT);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        j = '0;
    logic [7:0]        k = '0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready, wr_en, busy, done;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;

    generator_addr_out #(
        .END_ROW (END_ROW),
        .HEIGHT  (HEIGHT),
        .DATA_W  (DATA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .j        (j),
        .k        (k),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: word n of a tile sits at row n%4, column n/4 of the tile.
    function automatic int unsigned model_addr(input int unsigned mj, input int unsigned mk,
                                               input int unsigned n);
        int unsigned a;
        a = END_ROW * 4 * mk + 4 * mj + END_ROW * (n % 4) + n / 4;
        return a % HEIGHT;
    endfunction

    // Model: 0 = idle, 1 = collecting words, 2 = done cycle
    int          m_phase = 0;
    int unsigned m_n = 0, m_j = 0, m_k = 0;
    logic        e_wr_en = 1'b0;
    logic [31:0] e_addr = '0, e_data = '0;

    int          cyc = 0;
    int          wr_cnt = 0, done_cnt = 0, first_wr = -1, last_wr = -1, done_cyc = -1;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    always @(posedge clk) begin
        logic chk_ad;
        chk_ad = 1'b0;
        if (!rst) begin
            m_phase = 0; m_n = 0; m_j = 0; m_k = 0;
            e_wr_en = 1'b0; e_addr = '0; e_data = '0;
            chk_ad = 1'b1;
        end else begin
            e_wr_en = 1'b0;
            case (m_phase)
                0: if (start) begin
                    m_j = j; m_k = k; m_n = 0; m_phase = 1;
                end
                1: if (in_valid) begin
                    e_wr_en = 1'b1;
                    e_addr  = model_addr(m_j, m_k, m_n);
                    e_data  = 32'(in_data);
                    chk_ad  = 1'b1;
                    m_n++;
                    if (m_n == 16) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
        #1;
        cyc++;
        chk("wr_en", 32'(wr_en), 32'(e_wr_en));
        chk("done", 32'(done), 32'(m_phase == 2));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("in_ready", 32'(in_ready), 32'(m_phase == 1));
        if (chk_ad) begin
            chk("wr_addr", 32'(wr_addr), e_addr);
            chk("wr_data", 32'(wr_data), e_data);
        end
        if (wr_en) begin
            wr_cnt++;
            log_addr.push_back(32'(wr_addr));
            log_data.push_back(32'(wr_data));
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0]  k;
        logic [7:0]  j;
        int          n;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[17];
    int   exp_full[16] = '{24, 28, 32, 36, 25, 29, 33, 37, 26, 30, 34, 38, 27, 31, 35, 39};

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        wr_cnt = 0; done_cnt = 0; first_wr = -1; last_wr = -1; done_cyc = -1;
        log_addr.delete();
        log_data.delete();
    endtask

    // mode 0: continuous, 1: valid toggling 1,0,..., 2: random valid/data,
    // 3: continuous with a stray start (other j,k) held through the write and done cycle
    task automatic run_tile(input logic [7:0] tj, input logic [7:0] tk, input int mode,
                            input int words);
        int  n, c;
        logic v, acc;
        start = 1'b1; j = tj; k = tk; in_valid = 1'b0;
        tick();
        start = 1'b0;
        n = 0; c = 0;
        while (n < words && c < 400) begin
            if (mode == 1) v = (c % 2 == 0);
            else if (mode == 2) v = 1'($urandom_range(0, 1));
            else v = 1'b1;
            in_valid = v;
            in_data  = (mode == 2) ? DATA_W'($urandom) : DATA_W'(n);
            if (mode == 3) begin
                start = 1'b1; j = 8'd5; k = 8'd0;
            end
            acc = v && in_ready;
            tick();
            c++;
            if (acc) n++;
        end
        if (c >= 400) chk("tile_budget", 32'(n), 32'(words));
        in_valid = 1'b0;
        if (mode == 3 && words == 16) tick();
        start = 1'b0;
    endtask

    task automatic check_tile_log(input string name, input int first_vec);
        chk({name, "_wr_cnt"}, 32'(wr_cnt), 32'd16);
        chk({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({name, "_done_with_last"}, 32'(done_cyc), 32'(last_wr));
        if (log_addr.size() >= 16) begin
            for (int i = 0; i < 16; i++) begin
                chk({name, "_addr"}, log_addr[i], vecs[first_vec + i].addr);
                chk({name, "_data"}, log_data[i], 32'(vecs[first_vec + i].n));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) vecs[i] = '{8'd1, 8'd2, i, 32'(exp_full[i])};
        vecs[16] = '{8'd3, 8'd15, 0, 32'd44};

        // Reset held with start and in_valid high
        rst = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 16'hbeef;
        clear_log();
        repeat (3) tick();
        chk("reset_no_wr", 32'(wr_cnt), 32'd0);
        chk("reset_addr", 32'(wr_addr), 32'd0);
        chk("reset_data", 32'(wr_data), 32'd0);
        start = 1'b0; in_valid = 1'b0; rst = 1'b1;
        tick();

        // Full tile, continuous
        clear_log();
        run_tile(8'd2, 8'd1, 0, 16);
        repeat (3) tick();
        check_tile_log("full", 0);
        chk("full_back_to_back", 32'(last_wr - first_wr), 32'd15);

        // Stalled tile
        clear_log();
        run_tile(8'd2, 8'd1, 1, 16);
        repeat (3) tick();
        check_tile_log("stall", 0);

        // Address wrap modulo buffer depth
        clear_log();
        run_tile(vecs[16].j, vecs[16].k, 0, 16);
        repeat (3) tick();
        if (log_addr.size() > 0) chk("wrap_first_addr", log_addr[0], vecs[16].addr);
        else chk("wrap_first_addr_present", 32'(log_addr.size()), 32'd1);

        // Reset mid-tile after 7 accepts
        clear_log();
        run_tile(8'd2, 8'd1, 0, 7);
        tick();
        rst = 1'b0; in_valid = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        chk("midreset_wr_cnt", 32'(wr_cnt), 32'd7);
        chk("midreset_done_cnt", 32'(done_cnt), 32'd0);
        clear_log();
        run_tile(8'd2, 8'd1, 0, 16);
        repeat (3) tick();
        check_tile_log("restart", 0);

        // Stray start during WRITE and DONE
        clear_log();
        run_tile(8'd2, 8'd1, 3, 16);
        repeat (3) tick();
        check_tile_log("stray_start", 0);

        // Randomized tiles against the reference model
        for (int t = 0; t < 12; t++) begin
            clear_log();
            run_tile(8'($urandom), 8'($urandom), 2, 16);
            repeat ($urandom_range(1, 4)) tick();
            chk("rand_wr_cnt", 32'(wr_cnt), 32'd16);
            chk("rand_done_cnt", 32'(done_cnt), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
